pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Parametrised hazard/stall controller for the 5-stage RISC-V pipeline, between ID and the ID/EX register.
//  Detects load-use hazards and inserts LOAD_LAT bubbles; flushes IF/ID and ID/EX on taken branch/jump.
//  Freezes the whole pipe while data memory is busy; counts stall and flush events.
//  Feeds PC enable, IF/ID enable/flush and a gated ID control bundle into ID/EX.
// PARAMETERS
//  RA_W      5   register address width
//  CTRL_W    14  width of packed ID control bundle (RegWrite..AUIPC, ALU_CC)
//  INSTR_W   32  instruction width
//  LOAD_LAT  1   load-use bubbles inserted, legal 1..4
//  CNT_W     16  width of each performance counter
// PORTS
//  clk            in   1        pipeline clock, rising edge
//  reset          in   1        asynchronous, active-low reset
//  ex_memread     in   1        instruction in EX is a load
//  ex_rd          in   RA_W     destination register of EX instruction
//  id_rs1, id_rs2 in   RA_W     ID source registers
//  id_use_rs1/2   in   1        ID instruction actually reads rs1 / rs2
//  ex_redirect    in   1        taken branch/JAL/JALR resolved in EX
//  mem_busy       in   1        data memory not ready; freeze pipe
//  stat_clr       in   1        synchronous clear of both counters
//  ctrl_id        in   CTRL_W   ID control bundle
//  instr_id       in   INSTR_W  ID instruction
//  pc_en          out  1        PC register write enable
//  ifid_en        out  1        IF/ID write enable
//  ifid_flush     out  1        IF/ID load NOP (synchronous, at this edge)
//  pipe_en        out  1        enable for ID/EX, EX/MEM, MEM/WB
//  ctrl_ex        out  CTRL_W   ctrl_id, or zero when bubbling
//  instr_ex       out  INSTR_W  instr_id, or zero when bubbling
//  stall_cnt      out  CNT_W    cycles with a load-use bubble inserted
//  flush_cnt      out  CNT_W    redirect events taken
// BEHAVIOUR
//  lu_hit = ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  FSM states RUN, LU_STALL; down-counter bcnt, width clog2(LOAD_LAT+1).
//  Priority per cycle: reset > mem_busy > ex_redirect > LU_STALL > lu_hit > normal.
//  mem_busy=1: pc_en=ifid_en=pipe_en=0, ifid_flush=0, ctrl/instr pass; state, bcnt, counters hold.
//  ex_redirect (mem_busy=0): pc_en=1, ifid_en=1, ifid_flush=1, ctrl_ex=0, instr_ex=0, pipe_en=1;
//   next state RUN, bcnt=0; flush_cnt+1. Overrides lu_hit and aborts LU_STALL.
//  RUN & lu_hit: pc_en=ifid_en=0, ctrl_ex=instr_ex=0, pipe_en=1; stall_cnt+1;
//   LOAD_LAT==1 -> stay RUN; else -> LU_STALL, bcnt=LOAD_LAT-1.
//  LU_STALL: same outputs as lu_hit (detection ignored); stall_cnt+1; bcnt-1; bcnt==1 -> RUN next.
//  Normal: pc_en=ifid_en=pipe_en=1, ifid_flush=0, ctrl_ex=ctrl_id, instr_ex=instr_id.
//  Latency: all outputs combinational from inputs+state, same cycle; no added pipeline latency.
//  Counters saturate at all-ones (no wrap); stat_clr=1 zeroes both, wins over increment.
//  Reset low: state=RUN, bcnt=0, counters=0; outputs forced pc_en=ifid_en=pipe_en=0,
//   ifid_flush=1, ctrl_ex=0, instr_ex=0. Reset mid-LU_STALL abandons the stall.
//  Release: first edge after reset high runs normally.
// TESTING
//  lw x5 in EX, ID add x6,x5,x7, LOAD_LAT=1 -> 1 cycle pc_en=0, ctrl_ex=0; stall_cnt=1; next cycle pass.
//  LOAD_LAT=3, same hazard -> exactly 3 bubble cycles (RUN,LU_STALL,LU_STALL); stall_cnt=3.
//  ex_rd=0 or id_use_rs2=0 with rs2 match -> no bubble; ex_memread=0 -> no bubble.
//  lu_hit and ex_redirect same cycle -> ifid_flush=1, pc_en=1, stall_cnt unchanged, flush_cnt+1.
//  mem_busy high 5 cycles inside LU_STALL (LOAD_LAT=3) -> all enables 0, bcnt frozen, resumes after.
//  CNT_W=4, 20 hazards -> stall_cnt holds 15; stat_clr -> 0; reset mid-stall -> RUN, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller sitting between ID and the ID/EX register of a
// 5-stage RISC-V pipeline. It inserts LOAD_LAT bubbles on a load-use hazard,
// flushes IF/ID and ID/EX on a taken redirect, and freezes the pipe while
// data memory is busy. All pipe controls are combinational from the inputs
// and the current state, so no latency is added. Two saturating counters
// track bubble cycles and redirects.
//
// Valid/ready contract: mem_busy acts as "not ready" for the whole pipe.
// While it is high, no register advances: no PC, IF/ID, ID/EX or later
// stage and no internal state or counter. A redirect, hazard or bubble
// takes effect only in a cycle where mem_busy is low.
module pipeline_hazard_ctrl #(
  parameter int RA_W     = 5,
  parameter int CTRL_W   = 14,
  parameter int INSTR_W  = 32,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_memread,
  input  logic [RA_W-1:0]    ex_rd,
  input  logic [RA_W-1:0]    id_rs1,
  input  logic [RA_W-1:0]    id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic               ex_redirect,
  input  logic               mem_busy,
  input  logic               stat_clr,
  input  logic [CTRL_W-1:0]  ctrl_id,
  input  logic [INSTR_W-1:0] instr_id,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic               pipe_en,
  output logic [CTRL_W-1:0]  ctrl_ex,
  output logic [INSTR_W-1:0] instr_ex,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic               state_dbg
);

  localparam int BC_W = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  state_t          state;
  logic [BC_W-1:0] bcnt;
  logic            lu_hit;
  logic            redirect_go;
  logic            bubble;

  // Load-use detection against the instruction currently in EX; x0 never hazards.
  assign lu_hit = ex_memread && (ex_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));

  // A redirect beats any bubble; once in LU_STALL, detection is ignored.
  assign redirect_go = !mem_busy && ex_redirect;
  assign bubble      = !mem_busy && !ex_redirect && ((state == LU_STALL) || lu_hit);
  assign state_dbg   = state;

  // Pipe control outputs in priority order: reset, freeze, redirect, bubble, normal.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    pipe_en    = 1'b1;
    ctrl_ex    = ctrl_id;
    instr_ex   = instr_id;
    if (!reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      pipe_en    = 1'b0;
      ctrl_ex    = '0;
      instr_ex   = '0;
    end else if (mem_busy) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
    end else if (redirect_go) begin
      ifid_flush = 1'b1;
      ctrl_ex    = '0;
      instr_ex   = '0;
    end else if (bubble) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      ctrl_ex  = '0;
      instr_ex = '0;
    end
  end

  // Stall FSM: bcnt counts the bubbles still owed after the detection cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      bcnt  <= '0;
    end else if (!mem_busy) begin
      if (ex_redirect) begin
        state <= RUN;
        bcnt  <= '0;
      end else if (state == LU_STALL) begin
        bcnt <= bcnt - BC_W'(1);
        if (bcnt == BC_W'(1)) state <= RUN;
      end else if (lu_hit && (LOAD_LAT > 1)) begin
        state <= LU_STALL;
        bcnt  <= BC_W'(LOAD_LAT - 1);
      end
    end
  end

  // Saturating event counters; a clear takes precedence over an increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bubble && (stall_cnt != {CNT_W{1'b1}}))      stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_go && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances share stimulus, one with
// LOAD_LAT=1/CNT_W=16 and one with LOAD_LAT=3/CNT_W=4. Each is compared
// every cycle against a bubble-owed reference model, first under directed
// scenarios and then under random traffic.
module tb_pipeline_hazard_ctrl;

  localparam int RA_W = 5, CTRL_W = 14, INSTR_W = 32;
  localparam int LAT_A = 1, CW_A = 16, LAT_B = 3, CW_B = 4;
  localparam int MAX_A = (1 << CW_A) - 1, MAX_B = (1 << CW_B) - 1;

  // clock/reset block
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic               ex_memread, id_use_rs1, id_use_rs2, ex_redirect, mem_busy, stat_clr;
  logic [RA_W-1:0]    ex_rd, id_rs1, id_rs2;
  logic [CTRL_W-1:0]  ctrl_id;
  logic [INSTR_W-1:0] instr_id;

  logic               a_pc_en, a_ifid_en, a_ifid_flush, a_pipe_en, a_state;
  logic [CTRL_W-1:0]  a_ctrl_ex;
  logic [INSTR_W-1:0] a_instr_ex;
  logic [CW_A-1:0]    a_stall_cnt, a_flush_cnt;
  logic               b_pc_en, b_ifid_en, b_ifid_flush, b_pipe_en, b_state;
  logic [CTRL_W-1:0]  b_ctrl_ex;
  logic [INSTR_W-1:0] b_instr_ex;
  logic [CW_B-1:0]    b_stall_cnt, b_flush_cnt;

  pipeline_hazard_ctrl #(.RA_W(RA_W), .CTRL_W(CTRL_W), .INSTR_W(INSTR_W),
                         .LOAD_LAT(LAT_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .reset(reset), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .stat_clr(stat_clr),
    .ctrl_id(ctrl_id), .instr_id(instr_id), .pc_en(a_pc_en), .ifid_en(a_ifid_en),
    .ifid_flush(a_ifid_flush), .pipe_en(a_pipe_en), .ctrl_ex(a_ctrl_ex),
    .instr_ex(a_instr_ex), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt),
    .state_dbg(a_state));

  pipeline_hazard_ctrl #(.RA_W(RA_W), .CTRL_W(CTRL_W), .INSTR_W(INSTR_W),
                         .LOAD_LAT(LAT_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .reset(reset), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .stat_clr(stat_clr),
    .ctrl_id(ctrl_id), .instr_id(instr_id), .pc_en(b_pc_en), .ifid_en(b_ifid_en),
    .ifid_flush(b_ifid_flush), .pipe_en(b_pipe_en), .ctrl_ex(b_ctrl_ex),
    .instr_ex(b_instr_ex), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt),
    .state_dbg(b_state));

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  // reference model: bubbles still owed plus event counts, per instance
  int rem_a = 0, stall_a = 0, flsh_a = 0;
  int rem_b = 0, stall_b = 0, flsh_b = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hit();
    return ex_memread && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  // Expected pipe controls for one instance given the bubbles it still owes.
  task automatic model_out(input int rem, output logic pc, output logic ifd,
                           output logic fl, output logic pp,
                           output logic [CTRL_W-1:0] c, output logic [INSTR_W-1:0] ins);
    pc = 1; ifd = 1; fl = 0; pp = 1; c = ctrl_id; ins = instr_id;
    if (!reset) begin
      pc = 0; ifd = 0; fl = 1; pp = 0; c = '0; ins = '0;
    end else if (mem_busy) begin
      pc = 0; ifd = 0; pp = 0;
    end else if (ex_redirect) begin
      fl = 1; c = '0; ins = '0;
    end else if (rem > 0 || model_hit()) begin
      pc = 0; ifd = 0; c = '0; ins = '0;
    end
  endtask

  // Advance one instance's model across a rising edge.
  task automatic model_step(inout int rem, inout int st, inout int fc,
                            input int lat, input int maxv);
    if (!reset) begin
      rem = 0; st = 0; fc = 0;
    end else begin
      if (!mem_busy) begin
        if (ex_redirect) begin
          rem = 0;
          if (fc < maxv) fc++;
        end else if (rem > 0) begin
          rem--;
          if (st < maxv) st++;
        end else if (model_hit()) begin
          rem = lat - 1;
          if (st < maxv) st++;
        end
      end
      if (stat_clr) begin
        st = 0; fc = 0;
      end
    end
  endtask

  // Compare both instances against the model, then step over one clock.
  task automatic run_cycle();
    logic pc, ifd, fl, pp;
    logic [CTRL_W-1:0]  c;
    logic [INSTR_W-1:0] ins;
    #1;
    if (!reset) begin
      rem_a = 0; stall_a = 0; flsh_a = 0;
      rem_b = 0; stall_b = 0; flsh_b = 0;
    end
    model_out(rem_a, pc, ifd, fl, pp, c, ins);
    check("a_pc_en", a_pc_en, pc);
    check("a_ifid_en", a_ifid_en, ifd);
    check("a_ifid_flush", a_ifid_flush, fl);
    check("a_pipe_en", a_pipe_en, pp);
    check("a_ctrl_ex", a_ctrl_ex, c);
    check("a_instr_ex", a_instr_ex, ins);
    check("a_stall_cnt", a_stall_cnt, stall_a);
    check("a_flush_cnt", a_flush_cnt, flsh_a);
    check("a_state", a_state, 1'b0);
    model_out(rem_b, pc, ifd, fl, pp, c, ins);
    check("b_pc_en", b_pc_en, pc);
    check("b_ifid_en", b_ifid_en, ifd);
    check("b_ifid_flush", b_ifid_flush, fl);
    check("b_pipe_en", b_pipe_en, pp);
    check("b_ctrl_ex", b_ctrl_ex, c);
    check("b_instr_ex", b_instr_ex, ins);
    check("b_stall_cnt", b_stall_cnt, stall_b);
    check("b_flush_cnt", b_flush_cnt, flsh_b);
    check("b_state", b_state, (rem_b > 0) ? 1'b1 : 1'b0);
    @(posedge clk);
    model_step(rem_a, stall_a, flsh_a, LAT_A, MAX_A);
    model_step(rem_b, stall_b, flsh_b, LAT_B, MAX_B);
    @(negedge clk);
  endtask

  // driver task: apply one cycle of inputs at the falling edge
  task automatic apply(input logic mr, input int rd, input int r1, input int r2,
                       input logic u1, input logic u2, input logic rdr,
                       input logic bsy, input logic clr);
    ex_memread  = mr;
    ex_rd       = RA_W'(rd);
    id_rs1      = RA_W'(r1);
    id_rs2      = RA_W'(r2);
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    ex_redirect = rdr;
    mem_busy    = bsy;
    stat_clr    = clr;
    ctrl_id     = CTRL_W'($urandom);
    instr_id    = $urandom;
    run_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // lw x5 in EX, ID reads x5 as rs1
  task automatic hazard();
    apply(1, 5, 5, 7, 1, 1, 0, 0, 0);
  endtask

  initial begin
    ex_memread = 0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0;
    id_use_rs2 = 0; ex_redirect = 0; mem_busy = 0; stat_clr = 0;
    ctrl_id = '0; instr_id = '0;
    @(negedge clk);

    // reset held low: forced outputs
    idle(2);
    reset = 1'b1;
    idle(1);

    // single load-use hazard: one bubble for LAT 1, three for LAT 3
    hazard();
    idle(3);
    check("a_stall_after_lw", a_stall_cnt, 1);
    check("b_stall_after_lw", b_stall_cnt, 3);

    // no-bubble cases: ex_rd=0, rs2 match but unused, not a load
    apply(1, 0, 0, 0, 1, 1, 0, 0, 0);
    apply(1, 6, 1, 6, 1, 0, 0, 0, 0);
    apply(0, 5, 5, 5, 1, 1, 0, 0, 0);
    check("b_stall_no_hazard", b_stall_cnt, 3);

    // hazard and redirect together: redirect wins
    apply(1, 5, 5, 7, 1, 1, 1, 0, 0);
    check("a_flush_on_redirect", a_flush_cnt, 1);
    check("b_stall_on_redirect", b_stall_cnt, 3);

    // freeze for 5 cycles inside the LAT 3 stall, then resume
    hazard();
    for (int i = 0; i < 5; i++) apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    check("b_stall_after_freeze", b_stall_cnt, 6);

    // 20 hazards saturate the 4-bit counter, then clear
    for (int i = 0; i < 20; i++) begin
      hazard();
      idle(2);
    end
    check("b_stall_saturated", b_stall_cnt, 15);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("b_stall_cleared", b_stall_cnt, 0);
    check("a_stall_cleared", a_stall_cnt, 0);

    // reset in the middle of a stall abandons it
    hazard();
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(1);
    check("b_state_after_reset", b_state, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic bsy;
      reset = ($urandom_range(0, 99) != 0);
      bsy   = ($urandom_range(0, 6) == 0);
      apply(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0), bsy,
            (!bsy && $urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
